dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequencer/arbiter in front of data_memory (1 KiB, big-endian, 64-bit bus, comb read, sync write).
//  Shares it between two requesters (p0 = core LSU, p1 = debug/DMA) with round-robin arbitration.
//  Adds byte/half/word access: loads extract and sign/zero-extend; sub-doubleword stores use read-modify-write.
// PARAMETERS
//  MEM_BYTES  1024  memory size in bytes; bounds check limit
//  ADDR_W     10    effective address bits (addr[ADDR_W-1:0]); upper bits ignored
// PORTS
//  clk               in   1   clock
//  reset             in   1   asynchronous, active-high reset
//  p0_req/p1_req     in   1   request; held with its fields until ack
//  p0_we/p1_we       in   1   1=store, 0=load
//  p0_size/p1_size   in   2   0=B,1=H,2=W,3=D; n = 1<<size bytes
//  p0_uns/p1_uns     in   1   load zero-extend (1) / sign-extend (0)
//  p0_addr/p1_addr   in   64  byte address, no alignment required
//  p0_wdata/p1_wdata in   64  store data, right-justified (low 8n bits)
//  p0_ack/p1_ack     out  1   one-cycle completion pulse
//  p0_err/p1_err     out  1   valid with ack: out-of-range access
//  p0_rdata/p1_rdata out  64  load result, valid with ack; 0 otherwise
//  mem_address       out  64  to data_memory.address
//  mem_write_data    out  64  to data_memory.write_data
//  mem_read          out  1   to data_memory.mem_read
//  mem_write         out  1   to data_memory.mem_write
//  mem_read_data     in   64  from data_memory.read_data
//  busy              out  1   FSM not IDLE
// BEHAVIOUR
//  Reset: state=IDLE, last=1 (p0 wins first), all outputs 0, latched fields cleared.
//  FSM IDLE -> ACCESS -> [WRITE] -> DONE -> IDLE.
//  IDLE: if any req: grant p0 if only p0, p1 if only p1, both -> port != last;
//   latch port id, we, size, uns, addr, wdata; go ACCESS. No req: stay.
//  ACCESS: mem_address = latched addr.
//   err = addr[ADDR_W-1:0] + n > MEM_BYTES -> no mem_read/mem_write, go DONE.
//   load: mem_read=1; rdata_q = ext(mem_read_data[63 -: 8n]); go DONE.
//   store D: mem_write=1, mem_write_data=wdata; go DONE.
//   store B/H/W: mem_read=1; buf = {wdata[8n-1:0], mem_read_data[63-8n:0]}; go WRITE.
//  WRITE: mem_address = addr, mem_write=1, mem_write_data=buf; go DONE.
//  DONE: granted port's ack=1, err, rdata=rdata_q (0 for stores/err); last=port; go IDLE.
//  Latency from grant edge: load / store D / err = ack 2 cycles later; partial store = 3.
//  mem_read, mem_write decoded from state only; never both high; 0 in IDLE/DONE.
//  Requester sees ack, drops req next cycle; req still high in IDLE = new request.
//  Non-granted req waits; no preemption; at most one access in flight.
//  Async reset mid-op: FSM -> IDLE immediately, mem_write drops, pending ack discarded.
//  Fields changed while req held are ignored (latched in IDLE).
// TESTING
//  1. p0 store D 0x0123456789ABCDEF @0x010 -> one mem_write pulse, ack at +2;
//     load D @0x010 -> rdata 0x0123456789ABCDEF.
//  2. After 1, store B 0xAA @0x012 -> mem_read cycle then mem_write of 0xAA6789ABCDEF0000 @0x012, ack at +3;
//     load D @0x010 -> 0x0123AA6789ABCDEF.
//  3. After 2: load B signed @0x012 -> 0xFFFFFFFFFFFFFFAA; unsigned -> 0x00000000000000AA;
//     load H signed @0x010 -> 0x0000000000000123.
//  4. p0, p1 loads same cycle after reset -> p0 ack cycle 2, p1 ack cycle 5;
//     p0 re-requests while p1 pending -> p1 served first.
//  5. load D @0x3FC -> ack with err=1, rdata 0, no mem_read/mem_write; store B @0x3FF -> ok, err=0.
//  6. Assert reset during WRITE of a partial store -> mem_write=0 same cycle, no ack, busy=0, next request served normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Round-robin sequencer in front of a big-endian 64-bit data memory. Two requesters share it;
// sub-doubleword loads are extracted/extended and sub-doubleword stores use read-modify-write.
module dmem_access_ctrl #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic        p0_uns,
  input  logic [63:0] p0_addr,
  input  logic [63:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [63:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic        p1_uns,
  input  logic [63:0] p1_addr,
  input  logic [63:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [63:0] p1_rdata,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_read_data,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StWrite, StDone} state_e;

  state_e      state_q;
  logic        last_q;
  logic        port_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] buf_q;

  logic        grant_p1;
  logic [3:0]  nbytes;
  logic [31:0] end_addr;
  logic        acc_err;
  logic [6:0]  lane_shift;
  logic [63:0] lane;
  logic [63:0] load_ext;
  logic [63:0] merge;
  logic        is_dword_store;

  // p1 wins only when alone or when p0 was served last
  assign grant_p1 = p1_req && (!p0_req || !last_q);

  always_comb begin
    nbytes         = 4'd1 << size_q;
    end_addr       = 32'(addr_q[ADDR_W-1:0]) + 32'(nbytes);
    acc_err        = end_addr > MEM_BYTES;
    is_dword_store = we_q && (size_q == 2'd3);
    // Big-endian: the addressed bytes sit at the top of the read word
    lane_shift     = 7'd64 - {nbytes, 3'b000};
    lane           = mem_read_data >> lane_shift;
    merge          = (mem_read_data & ~({64{1'b1}} << lane_shift)) | (wdata_q << lane_shift);
    load_ext       = lane;
    unique case (size_q)
      2'd0: load_ext = uns_q ? {56'd0, lane[7:0]}  : {{56{lane[7]}}, lane[7:0]};
      2'd1: load_ext = uns_q ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      2'd2: load_ext = uns_q ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      2'd3: load_ext = lane;
    endcase
  end

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    unique case (state_q)
      StAccess: begin
        mem_address = addr_q;
        if (!acc_err) begin
          if (is_dword_store) begin
            mem_write      = 1'b1;
            mem_write_data = wdata_q;
          end else begin
            mem_read = 1'b1;
          end
        end
      end
      StWrite: begin
        mem_address    = addr_q;
        mem_write      = 1'b1;
        mem_write_data = buf_q;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      p0_ack   <= 1'b0;
      p0_err   <= 1'b0;
      p0_rdata <= '0;
      p1_ack   <= 1'b0;
      p1_err   <= 1'b0;
      p1_rdata <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (p0_req || p1_req) begin
            port_q  <= grant_p1;
            we_q    <= grant_p1 ? p1_we    : p0_we;
            size_q  <= grant_p1 ? p1_size  : p0_size;
            uns_q   <= grant_p1 ? p1_uns   : p0_uns;
            addr_q  <= grant_p1 ? p1_addr  : p0_addr;
            wdata_q <= grant_p1 ? p1_wdata : p0_wdata;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (!acc_err && we_q && !is_dword_store) begin
            buf_q   <= merge;
            state_q <= StWrite;
          end else begin
            p0_ack   <= !port_q;
            p1_ack   <= port_q;
            p0_err   <= !port_q && acc_err;
            p1_err   <= port_q && acc_err;
            p0_rdata <= (!port_q && !acc_err && !we_q) ? load_ext : '0;
            p1_rdata <= (port_q && !acc_err && !we_q) ? load_ext : '0;
            state_q  <= StDone;
          end
        end
        StWrite: begin
          p0_ack  <= !port_q;
          p1_ack  <= port_q;
          state_q <= StDone;
        end
        StDone: begin
          p0_ack   <= 1'b0;
          p0_err   <= 1'b0;
          p0_rdata <= '0;
          p1_ack   <= 1'b0;
          p1_err   <= 1'b0;
          p1_rdata <= '0;
          last_q   <= port_q;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural big-endian byte memory behind it.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req = 0, p0_we = 0, p0_uns = 0;
  logic [1:0]  p0_size = 0;
  logic [63:0] p0_addr = 0, p0_wdata = 0;
  logic        p1_req = 0, p1_we = 0, p1_uns = 0;
  logic [1:0]  p1_size = 0;
  logic [63:0] p1_addr = 0, p1_wdata = 0;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [63:0] p0_rdata, p1_rdata;
  logic [63:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read, mem_write, busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:1023] = '{default: 8'h00};
  int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [63:0] last_wa = '0, last_wd = '0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.MEM_BYTES(1024), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_uns(p0_uns),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_err(p0_err),
    .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_uns(p1_uns),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_err(p1_err),
    .p1_rdata(p1_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
    .busy(busy)
  );

  // Combinational big-endian read; bytes past the end read as zero
  always_comb begin
    mem_read_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (int'(mem_address[10:0]) + i < 1024)
        mem_read_data[63-8*i -: 8] = mem[int'(mem_address[10:0]) + i];
    end
  end

  always @(posedge clk) begin
    if (mem_write) begin
      for (int i = 0; i < 8; i++) begin
        if (int'(mem_address[10:0]) + i < 1024)
          mem[int'(mem_address[10:0]) + i] <= mem_write_data[63-8*i -: 8];
      end
    end
  end

  always @(negedge clk) begin
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_write) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_address;
      last_wd <= mem_write_data;
    end
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
  end

  // Issue one request on a port; lat counts posedges from the request cycle to ack (-1 = none)
  task automatic do_access(input bit port, input bit we, input logic [1:0] size, input bit uns,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           output int lat, output logic err, output logic [63:0] rdata);
    @(negedge clk);
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    if (!port) begin
      p0_we = we; p0_size = size; p0_uns = uns; p0_addr = addr; p0_wdata = wdata; p0_req = 1;
    end else begin
      p1_we = we; p1_size = size; p1_uns = uns; p1_addr = addr; p1_wdata = wdata; p1_req = 1;
    end
    lat = -1; err = 1'b0; rdata = '0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (port ? p1_ack : p0_ack) begin
        lat = c;
        err = port ? p1_err : p0_err;
        rdata = port ? p1_rdata : p0_rdata;
        break;
      end
    end
    p0_req = 0; p1_req = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || mem_address !== 64'd0 ||
        p0_ack !== 1'b0 || p1_ack !== 1'b0 || p0_rdata !== 64'd0 || p1_rdata !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b rd=%b wr=%b addr=%h ack=%b%b want all zero",
               busy, mem_read, mem_write, mem_address, p0_ack, p1_ack);
    end
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_store_load_d;
    int lat; logic err; logic [63:0] rd; int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    do_access(0, 1, 2'd3, 0, 64'h10, 64'h0123456789ABCDEF, lat, err, rd);
    checks++;
    if (lat !== 2 || err !== 1'b0 || rd !== 64'd0) begin
      errors++; $display("FAIL store_d: got lat=%0d err=%b rd=%h want 2 0 0", lat, err, rd);
    end
    checks++;
    if (wr_cnt - w0 != 1 || rd_cnt - r0 != 0 || last_wa !== 64'h10 ||
        last_wd !== 64'h0123456789ABCDEF) begin
      errors++;
      $display("FAIL store_d_bus: got wr=%0d rd=%0d addr=%h data=%h want 1 0 10 0123456789abcdef",
               wr_cnt - w0, rd_cnt - r0, last_wa, last_wd);
    end
    do_access(0, 0, 2'd3, 0, 64'h10, 64'h0, lat, err, rd);
    checks++;
    if (lat !== 2 || rd !== 64'h0123456789ABCDEF) begin
      errors++; $display("FAIL load_d: got lat=%0d rd=%h want 2 0123456789abcdef", lat, rd);
    end
  endtask

  task automatic test_partial_store;
    int lat; logic err; logic [63:0] rd; int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    do_access(0, 1, 2'd0, 0, 64'h12, 64'h11223344556677AA, lat, err, rd);
    checks++;
    if (lat !== 3 || err !== 1'b0) begin
      errors++; $display("FAIL store_b: got lat=%0d err=%b want 3 0", lat, err);
    end
    checks++;
    if (wr_cnt - w0 != 1 || rd_cnt - r0 != 1 || last_wa !== 64'h12 ||
        last_wd !== 64'hAA6789ABCDEF0000) begin
      errors++;
      $display("FAIL store_b_rmw: got wr=%0d rd=%0d addr=%h data=%h want 1 1 12 aa6789abcdef0000",
               wr_cnt - w0, rd_cnt - r0, last_wa, last_wd);
    end
    do_access(0, 0, 2'd3, 0, 64'h10, 64'h0, lat, err, rd);
    checks++;
    if (rd !== 64'h0123AA6789ABCDEF) begin
      errors++; $display("FAIL load_d_merged: got %h want 0123aa6789abcdef", rd);
    end
  endtask

  task automatic test_load_ext;
    int lat; logic err; logic [63:0] rd;
    do_access(0, 0, 2'd0, 0, 64'h12, 64'h0, lat, err, rd);
    checks++;
    if (rd !== 64'hFFFFFFFFFFFFFFAA) begin
      errors++; $display("FAIL load_b_signed: got %h want ffffffffffffffaa", rd);
    end
    do_access(1, 0, 2'd0, 1, 64'h12, 64'h0, lat, err, rd);
    checks++;
    if (lat !== 2 || rd !== 64'h00000000000000AA) begin
      errors++; $display("FAIL load_b_unsigned: got lat=%0d rd=%h want 2 aa", lat, rd);
    end
    do_access(0, 0, 2'd1, 0, 64'h10, 64'h0, lat, err, rd);
    checks++;
    if (rd !== 64'h0000000000000123) begin
      errors++; $display("FAIL load_h_signed: got %h want 0000000000000123", rd);
    end
    do_access(0, 0, 2'd2, 0, 64'h14, 64'h0, lat, err, rd);
    checks++;
    if (rd !== 64'hFFFFFFFF89ABCDEF) begin
      errors++; $display("FAIL load_w_signed: got %h want ffffffff89abcdef", rd);
    end
  endtask

  task automatic test_arbitration;
    int p0_c, p1_c, p0_c2; logic [63:0] p1_rd;
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
    p0_we = 0; p0_size = 2'd3; p0_uns = 0; p0_addr = 64'h10;
    p1_we = 0; p1_size = 2'd0; p1_uns = 1; p1_addr = 64'h12;
    p0_req = 1; p1_req = 1;
    p0_c = -1; p1_c = -1; p1_rd = '0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (p0_ack && p0_c < 0) begin p0_c = c; p0_req = 0; end
      if (p1_ack && p1_c < 0) begin p1_c = c; p1_rd = p1_rdata; p1_req = 0; end
    end
    p0_req = 0; p1_req = 0;
    checks++;
    if (p0_c != 2 || p1_c != 5 || p1_rd !== 64'hAA) begin
      errors++;
      $display("FAIL arb_both: got p0=%0d p1=%0d p1_rd=%h want 2 5 aa", p0_c, p1_c, p1_rd);
    end
    // p0 keeps its request up after its ack; p1 must be served before p0 again
    @(negedge clk);
    p0_req = 1; p1_req = 1;
    p0_c = -1; p1_c = -1; p0_c2 = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (p0_ack) begin
        if (p0_c < 0) p0_c = c;
        else if (p0_c2 < 0) begin p0_c2 = c; p0_req = 0; end
      end
      if (p1_ack && p1_c < 0) begin p1_c = c; p1_req = 0; end
    end
    p0_req = 0; p1_req = 0;
    checks++;
    if (p0_c != 2 || p1_c != 5 || p0_c2 != 8) begin
      errors++;
      $display("FAIL arb_rerequest: got p0=%0d p1=%0d p0b=%0d want 2 5 8", p0_c, p1_c, p0_c2);
    end
  endtask

  task automatic test_bounds;
    int lat; logic err; logic [63:0] rd; int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    do_access(0, 0, 2'd3, 0, 64'h3FC, 64'h0, lat, err, rd);
    checks++;
    if (lat !== 2 || err !== 1'b1 || rd !== 64'd0 || wr_cnt != w0 || rd_cnt != r0) begin
      errors++;
      $display("FAIL oob_load_d: got lat=%0d err=%b rd=%h memops=%0d want 2 1 0 0",
               lat, err, rd, (wr_cnt - w0) + (rd_cnt - r0));
    end
    do_access(1, 1, 2'd0, 0, 64'h3FF, 64'hFFFFFFFFFFFFFF5A, lat, err, rd);
    checks++;
    if (lat !== 3 || err !== 1'b0) begin
      errors++; $display("FAIL edge_store_b: got lat=%0d err=%b want 3 0", lat, err);
    end
    do_access(0, 0, 2'd0, 1, 64'h3FF, 64'h0, lat, err, rd);
    checks++;
    if (err !== 1'b0 || rd !== 64'h5A) begin
      errors++; $display("FAIL edge_load_b: got err=%b rd=%h want 0 5a", err, rd);
    end
  endtask

  task automatic test_reset_mid_write;
    int lat; logic err; logic [63:0] rd; int w0; logic seen_ack;
    @(negedge clk);
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    w0 = wr_cnt;
    p0_we = 1; p0_size = 2'd0; p0_uns = 0; p0_addr = 64'h20; p0_wdata = 64'h55; p0_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (mem_write !== 1'b1) begin
      errors++; $display("FAIL rmw_write_phase: got mem_write=%b want 1", mem_write);
    end
    #1 reset = 1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || busy !== 1'b0 || p0_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_write: got wr=%b busy=%b ack=%b want 0 0 0", mem_write, busy, p0_ack);
    end
    p0_req = 0;
    @(negedge clk) reset = 0;
    seen_ack = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (p0_ack || p1_ack) seen_ack = 1'b1;
    end
    checks++;
    if (seen_ack !== 1'b0 || wr_cnt != w0 || mem[32] !== 8'h00) begin
      errors++;
      $display("FAIL reset_discard: got ack=%b writes=%0d byte=%h want 0 0 00",
               seen_ack, wr_cnt - w0, mem[32]);
    end
    do_access(0, 1, 2'd0, 0, 64'h20, 64'h55, lat, err, rd);
    do_access(0, 0, 2'd0, 1, 64'h20, 64'h0, lat, err, rd);
    checks++;
    if (lat !== 2 || rd !== 64'h55) begin
      errors++; $display("FAIL after_reset_access: got lat=%0d rd=%h want 2 55", lat, rd);
    end
  endtask

  initial begin
    test_reset();
    test_store_load_d();
    test_partial_store();
    test_load_ext();
    test_arbitration();
    test_bounds();
    test_reset_mid_write();
    checks++;
    if (both_cnt != 0) begin
      errors++; $display("FAIL read_write_exclusive: got %0d overlaps want 0", both_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
